// File: rtl/lif_array.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons sharing one update
// datapath; per-neuron membrane and refractory state live in internal arrays.
module lif_array #(
    parameter int N_NEURONS  = 64,
    parameter int WIDTH      = 16,
    parameter int THRESH     = 32,
    parameter int RESET_VAL  = 0,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    localparam int IDX_W     = $clog2(N_NEURONS),
    localparam int REFR_W    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    spk_valid,
    output logic                    spk_out,
    output logic [IDX_W-1:0]        spk_idx,
    output logic signed [WIDTH-1:0] mem_out,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RUN} state_t;

    localparam logic signed [WIDTH-1:0] MEM_RST   = WIDTH'(RESET_VAL);
    localparam logic signed [WIDTH-1:0] THR       = WIDTH'(THRESH);
    localparam logic [REFR_W-1:0]       REFR_LOAD = REFR_W'(REFRAC);
    localparam logic [REFR_W-1:0]       REFR_ONE  = REFR_W'(1);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(N_NEURONS - 1);

    logic signed [WIDTH-1:0] r_mem  [N_NEURONS];
    logic [REFR_W-1:0]       r_refr [N_NEURONS];

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_vld_p1;
    logic                    r_spk_p1;
    logic                    r_done_p1;
    logic [IDX_W-1:0]        r_idx_p1;
    logic signed [WIDTH-1:0] r_mem_p1;

    logic                    w_acc;
    logic                    w_fire;
    logic signed [WIDTH-1:0] w_m;
    logic signed [WIDTH-1:0] w_s;
    logic signed [WIDTH-1:0] w_m_next;
    logic [REFR_W-1:0]       w_r;
    logic [REFR_W-1:0]       w_r_next;

    // Add at WIDTH+1 bits and clamp back into the signed WIDTH range.
    function automatic logic signed [WIDTH-1:0] sat_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1])
            return sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return sum[WIDTH-1:0];
    endfunction

    // s - s/2^k never leaves the signed range, so no clamp is needed here.
    function automatic logic signed [WIDTH-1:0] leak(input logic signed [WIDTH-1:0] s);
        if (LEAK_SHIFT == 0)
            return s;
        return s - (s >>> LEAK_SHIFT);
    endfunction

    assign in_ready = (r_state == ST_RUN);
    assign busy     = (r_state != ST_IDLE);
    assign w_acc    = in_ready & in_valid;

    // Stage p0: read neuron state and compute its update in the same cycle.
    always_comb begin
        w_m      = r_mem[r_idx];
        w_r      = r_refr[r_idx];
        w_s      = sat_add(w_m, in_data);
        w_fire   = 1'b0;
        w_m_next = MEM_RST;
        w_r_next = '0;
        if (w_r != '0) begin
            w_r_next = w_r - REFR_ONE;
        end else if (w_s >= THR) begin
            w_fire   = 1'b1;
            w_r_next = REFR_LOAD;
        end else begin
            w_m_next = leak(w_s);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_idx]  <= MEM_RST;
            r_refr[r_idx] <= '0;
        end else if (w_acc) begin
            r_mem[r_idx]  <= w_m_next;
            r_refr[r_idx] <= w_r_next;
        end
    end

    // Stage p1: registered result, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_idx     <= '0;
            r_vld_p1  <= 1'b0;
            r_spk_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            r_idx_p1  <= '0;
            r_mem_p1  <= '0;
        end else begin
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    r_idx <= '0;
                    if (start)
                        r_state <= ST_RUN;
                    else if (clear)
                        r_state <= ST_CLEAR;
                end
                ST_RUN: begin
                    if (w_acc) begin
                        r_vld_p1  <= 1'b1;
                        r_spk_p1  <= w_fire;
                        r_mem_p1  <= w_m_next;
                        r_idx_p1  <= r_idx;
                        r_done_p1 <= (r_idx == IDX_LAST);
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign spk_valid = r_vld_p1;
    assign spk_out   = r_spk_p1;
    assign spk_idx   = r_idx_p1;
    assign mem_out   = r_mem_p1;
    assign done      = r_done_p1;

endmodule
